// File: rtl/reg_link_pkg.sv
// Shared definitions for the register serial link: state encodings and line levels.
// The serial receiver on the far end of the link imports the same package.
package reg_link_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ENABLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ENABLE = ST_ENABLE,
    SAMPLE = ST_SAMPLE,
    START  = ST_START,
    DATA   = ST_DATA,
    STOP   = ST_STOP
  } link_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // The bit timer only runs while a serial bit is on the wire.
  function automatic logic in_frame(input link_state_e s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick pulses on the last cycle of every CLKS_PER_BIT-cycle period.
// The count is held at zero whenever run is low, so each frame starts on a fresh period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/register_read_tx.sv
// Reads the parallel register once per request and shifts it out as start, data (LSB first), stop.
// All outputs come straight from flops; the next-state logic decides them one edge ahead.
module register_read_tx
  import reg_link_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req,
  output logic             reg_oe,
  input  logic [WIDTH-1:0] reg_q,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  link_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             reg_oe_q, reg_oe_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run;
  logic             tick;

  assign run = in_frame(state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .clr (clr),
    .run (run),
    .tick(tick)
  );

  // sdo is loaded on the edge that enters each bit, so the shifter always holds the bits still to go.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    reg_oe_d  = reg_oe_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = ENABLE;
          reg_oe_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ENABLE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d   = START;
        shreg_d   = reg_q;
        reg_oe_d  = 1'b0;
        sdo_d     = LINE_START;
        bit_cnt_d = '0;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          sdo_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            sdo_d   = LINE_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sdo_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        reg_oe_d = 1'b0;
        sdo_d    = LINE_IDLE;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      reg_oe_q  <= 1'b0;
      sdo_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      reg_oe_q  <= reg_oe_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign reg_oe = reg_oe_q;
  assign sdo    = sdo_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_register_read_tx.sv
// Directed bench for register_read_tx: one instance at 4 clocks per bit, one at 1 clock per bit.
// Frame expectations are hand-written six-bit vectors {stop, d3..d0, start}, read LSB first.
module tb_register_read_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_a, req_b;
  logic [3:0] q_a, q_b;
  logic       oe_a, sdo_a, busy_a, done_a;
  logic       oe_b, sdo_b, busy_b, done_b;
  bit         sel_b;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  register_read_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .clr(clr), .req(req_a), .reg_oe(oe_a), .reg_q(q_a),
    .sdo(sdo_a), .busy(busy_a), .done(done_a)
  );

  register_read_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .clr(clr), .req(req_b), .reg_oe(oe_b), .reg_q(q_b),
    .sdo(sdo_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic get_oe();   return sel_b ? oe_b   : oe_a;   endfunction
  function automatic logic get_sdo();  return sel_b ? sdo_b  : sdo_a;  endfunction
  function automatic logic get_busy(); return sel_b ? busy_b : busy_a; endfunction
  function automatic logic get_done(); return sel_b ? done_b : done_a; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " reg_oe"}, get_oe(), 1'b0);
    checkOutput({tag, " sdo"}, get_sdo(), 1'b1);
    checkOutput({tag, " busy"}, get_busy(), 1'b0);
    checkOutput({tag, " done"}, get_done(), 1'b0);
  endtask

  task automatic applyStimulus(input logic r);
    if (sel_b) req_b = r;
    else       req_a = r;
  endtask

  task automatic setData(input logic [3:0] d);
    if (sel_b) q_b = d;
    else       q_a = d;
  endtask

  // Accepts a request, then checks every cycle up to and including the done cycle.
  task automatic runFrame(input int cpb, input logic [5:0] bits, input int change_t,
                          input logic [3:0] new_q, input bit keep_req);
    int   total;
    logic e_sdo;
    total = 2 + 6 * cpb;
    applyStimulus(1'b1);
    step();
    if (!keep_req) applyStimulus(1'b0);
    for (int t = 0; t <= total; t++) begin
      if (t < 2 || t >= total) e_sdo = 1'b1;
      else                     e_sdo = bits[(t - 2) / cpb];
      checkOutput($sformatf("reg_oe t=%0d", t), get_oe(), (t < 2));
      checkOutput($sformatf("sdo t=%0d", t), get_sdo(), e_sdo);
      checkOutput($sformatf("busy t=%0d", t), get_busy(), (t < total));
      checkOutput($sformatf("done t=%0d", t), get_done(), (t == total));
      if (t == change_t) setData(new_q);
      if (t < total) step();
    end
  endtask

  initial begin
    clr   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    q_a   = 4'b0000;
    q_b   = 4'b0000;
    sel_b = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      step();
      sel_b = 1'b0; checkIdle("reset a");
      sel_b = 1'b1; checkIdle("reset b");
    end
    sel_b = 1'b0;
    clr = 1'b0;
    step(); checkIdle("post reset");
    step(); checkIdle("post reset 2");

    $display("[TB] clr and req together");
    clr = 1'b1; req_a = 1'b1;
    step(); checkIdle("clr+req");
    clr = 1'b0; req_a = 1'b0;
    step(); checkIdle("clr+req after");

    $display("[TB] basic frame 0011");
    q_a = 4'b0011;
    runFrame(4, 6'b100110, -1, 4'b0000, 1'b0);
    step(); checkIdle("after basic");

    $display("[TB] data change after sample");
    q_a = 4'b1010;
    runFrame(4, 6'b110100, 3, 4'b0101, 1'b0);
    step(); checkIdle("after change");

    $display("[TB] req held high");
    q_a = 4'b1111;
    runFrame(4, 6'b111110, -1, 4'b0000, 1'b1);
    runFrame(4, 6'b111110, -1, 4'b0000, 1'b1);
    applyStimulus(1'b0);
    step(); checkIdle("after held");

    $display("[TB] reset mid-frame");
    q_a = 4'b0011;
    applyStimulus(1'b1);
    step();
    applyStimulus(1'b0);
    for (int i = 0; i < 15; i++) step();
    checkOutput("midframe bit2 sdo", get_sdo(), 1'b0);
    checkOutput("midframe busy", get_busy(), 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checkIdle("midframe clr");
    for (int i = 0; i < 30; i++) begin
      step();
      checkOutput($sformatf("abandoned done c=%0d", i), get_done(), 1'b0);
      checkOutput($sformatf("abandoned busy c=%0d", i), get_busy(), 1'b0);
    end
    runFrame(4, 6'b100110, -1, 4'b0000, 1'b0);
    step(); checkIdle("after recovery");

    $display("[TB] one clock per bit, 1001");
    sel_b = 1'b1;
    q_b = 4'b1001;
    runFrame(1, 6'b110010, -1, 4'b0000, 1'b0);
    step(); checkIdle("after cpb1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_read_tx.md
# register_read_tx

Reader/transmitter for the parallel-load register used elsewhere in this design. On request it enables the register's output (`reg_oe`), samples its WIDTH-bit `reg_q` value, and sends the value out serially on a single wire. The frame is a start bit, then data LSB first, then a stop bit. It converts stored parallel data into a serial stream for the board-level link, with a req/busy/done handshake toward the controlling logic.

## Interface
- WIDTH, default 4: data width of the register being read.
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held. Legal range is 1 or more.

- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- req  in  1  read-and-send request, sampled only in IDLE.
- reg_oe  out  1  output enable to the register, active-high.
- reg_q  in  WIDTH  register data, valid while reg_oe=1.
- sdo  out  1  serial data out; line idles high.
- busy  out  1  high from request acceptance until the frame ends.
- done  out  1  one-cycle pulse marking the end of the stop bit.

## Operation
- All outputs are registered.
- Reset values (clr=1 at an edge): reg_oe=0, sdo=1, busy=0, done=0. State=IDLE, shift register=0, counters=0.
- FSM states and transitions:
  - IDLE → ENABLE when req=1.
  - ENABLE → SAMPLE unconditionally. This is one settle cycle with reg_oe=1.
  - SAMPLE → START. At this edge: shift register ← reg_q, reg_oe ← 0.
  - START → DATA after CLKS_PER_BIT cycles, with sdo=0.
  - DATA → STOP after WIDTH bits. sdo=shreg[0]; the shift register shifts right every CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles, with sdo=1. done=1 for the single cycle after this transition.
- busy=1 in every state except IDLE.
- sdo=1 in IDLE, ENABLE and SAMPLE.
- req while busy=1 is ignored and not queued.
- reg_q is sampled exactly once per frame. Later changes on reg_q do not affect the frame in flight.
- Bit counter width: $clog2(WIDTH+1). Baud counter width: max(1, $clog2(CLKS_PER_BIT)). The baud counter runs from 0 up to CLKS_PER_BIT-1 and then wraps to 0.

## Timing
- req is sampled high at edge k. Then:
  - reg_oe=1 and busy=1 from edge k through edge k+2.
  - The start bit begins at edge k+2.
  - Data bit i occupies edges k+2+(i+1)·CLKS_PER_BIT onward.
  - The stop bit ends at edge k+2+(WIDTH+2)·CLKS_PER_BIT. At that edge: done=1, busy=0.
- Total latency from accepting req to done is 2+(WIDTH+2)·CLKS_PER_BIT cycles. With the defaults this is 26.
- Back-to-back requests: if req=1 is sampled on the cycle done=1, a new frame starts. In that case reg_oe rises at the next edge and sdo stays 1 until the next start bit.
- With CLKS_PER_BIT=1 each bit lasts exactly one cycle, and the FSM must not skip or repeat a bit.
- clr mid-frame: at the next edge all outputs take their reset values. The frame is abandoned, with no done pulse and no partial stop bit.
- clr and req asserted together: clr wins and the request is dropped.

## Structure
- Shared package `reg_link_pkg` holds:
  - the state encodings (IDLE, ENABLE, SAMPLE, START, DATA, STOP) as localparams, 3 bits;
  - the idle line level (1'b1) and the start-bit level (1'b0).
- The future serial receiver reuses this package.
- One sub-module, `bit_timer`:
  - parameter CLKS_PER_BIT;
  - inputs clk, clr, run;
  - output tick, a one-cycle pulse on the last cycle of each bit period.
- The counter clears whenever run=0.

## Test plan
- Reset: hold clr=1 for 3 cycles, then release. Required: reg_oe=0, sdo=1, busy=0, done=0 throughout and after release while req=0.
- Basic frame (WIDTH=4, CLKS_PER_BIT=4, reg_q=4'b0011), req pulsed for one cycle. Required:
  - reg_oe=1 for exactly 2 cycles;
  - sdo sequence 0,1,1,0,0,1, each bit held 4 cycles;
  - done pulses 26 cycles after req acceptance.
- Data change after sample: reg_q=4'b1010 at sample, then reg_q changed to 4'b0101 during the START state. Required: data bits on sdo are 0,1,0,1 (LSB first of 4'b1010).
- req held high continuously with reg_q=4'b1111. Required:
  - a second frame starts on the done cycle;
  - reg_oe re-asserts one cycle after done;
  - busy drops for exactly one cycle between frames.
- Reset mid-frame: clr=1 during the DATA state on bit 2. Required:
  - at the next edge sdo=1, busy=0, reg_oe=0;
  - no done pulse;
  - a new req afterwards produces a complete, correct frame.
- CLKS_PER_BIT=1, reg_q=4'b1001. Required: sdo is 0,1,0,0,1,1 on consecutive cycles, and done occurs 8 cycles after acceptance.
